// File: rtl/axi4lite_regbank_pkg.sv
// rtl/axi4lite_regbank_pkg.sv - shared response codes, FSM state types and byte-lane merge helper
package axi4lite_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Sized for the widest supported bus; callers cast to their data width.
  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_regbank_wr_ctrl.sv
// rtl/axi4lite_regbank_wr_ctrl.sv - AW/W capture, write FSM and B channel; emits one commit strobe per write
module axi4lite_regbank_wr_ctrl
  import axi4lite_regbank_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int NUM_REGS = 16,
  parameter int ADDR_LSB = $clog2(DW/8),
  parameter int IDXW     = AW - ADDR_LSB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  output logic            commit,
  output logic [IDXW-1:0] commit_idx,
  output logic [DW-1:0]   commit_data,
  output logic [DW/8-1:0] commit_strb
);

  wr_state_t       state, state_n;
  logic            aw_hold, aw_hold_n, w_hold, w_hold_n;
  logic            awready_n, wready_n, bvalid_n;
  logic [1:0]      bresp_n;
  logic [IDXW-1:0] idx_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic            aw_fire, w_fire, in_range;
  logic            unused_addr;

  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  // Bypass the holding registers so a same-edge AW/W pair commits immediately.
  assign commit_idx  = aw_fire ? awaddr[AW-1:ADDR_LSB] : idx_q;
  assign commit_data = w_fire ? wdata : data_q;
  assign commit_strb = w_fire ? wstrb : strb_q;
  assign in_range    = int'(commit_idx) < NUM_REGS;
  assign unused_addr = ^awaddr[ADDR_LSB-1:0];

  always_comb begin
    state_n   = state;
    aw_hold_n = aw_hold;
    w_hold_n  = w_hold;
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    commit    = 1'b0;
    case (state)
      W_IDLE: begin
        if (aw_fire) aw_hold_n = 1'b1;
        if (w_fire)  w_hold_n  = 1'b1;
        awready_n = !aw_hold_n;
        wready_n  = !w_hold_n;
        if (aw_hold_n && w_hold_n) begin
          commit   = 1'b1;
          bvalid_n = 1'b1;
          bresp_n  = in_range ? RESP_OKAY : RESP_SLVERR;
          state_n  = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          aw_hold_n = 1'b0;
          w_hold_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          state_n   = W_IDLE;
        end
      end
      default: state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= W_IDLE;
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state   <= state_n;
      aw_hold <= aw_hold_n;
      w_hold  <= w_hold_n;
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      if (aw_fire) idx_q <= awaddr[AW-1:ADDR_LSB];
      if (w_fire) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4lite_regbank.sv
// rtl/axi4lite_regbank.sv - parametrised AXI4-Lite register bank with RO registers and per-register access pulses
module axi4lite_regbank
  import axi4lite_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                reg_wr_pulse,
  output logic [NUM_REGS-1:0]                reg_rd_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int IDXW     = AW - ADDR_LSB;

  logic            commit;
  logic [IDXW-1:0] commit_idx;
  logic [DW-1:0]   commit_data;
  logic [DW/8-1:0] commit_strb;
  logic [NUM_REGS-1:0] wr_hit, rd_hit;

  axi4lite_regbank_wr_ctrl #(
    .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS), .ADDR_LSB(ADDR_LSB), .IDXW(IDXW)
  ) u_wr_ctrl (
    .clk(ACLK), .rst(ARESET),
    .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
    .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
    .bresp(S_AXI_BRESP), .bvalid(S_AXI_BVALID), .bready(S_AXI_BREADY),
    .commit(commit), .commit_idx(commit_idx), .commit_data(commit_data), .commit_strb(commit_strb)
  );

  // Read-only registers have no storage; they mirror reg_in directly.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_out[i*DW +: DW] = reg_in[i*DW +: DW];
    end else begin : g_rw
      logic [DW-1:0] r;
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)         r <= RESET_VALUES[i*DW +: DW];
        else if (wr_hit[i]) r <= DW'(apply_wstrb(64'(r), 64'(commit_data), 8'(commit_strb)));
      end
      assign reg_out[i*DW +: DW] = r;
    end
  end

  rd_state_t       rd_state, rd_state_n;
  logic            arready_n, rvalid_n;
  logic [1:0]      rresp_n;
  logic [DW-1:0]   rdata_n, rd_word;
  logic [IDXW-1:0] ar_idx;
  logic            ar_fire, ar_in_range;
  logic            unused_ok;

  assign ar_idx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign ar_fire     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_in_range = int'(ar_idx) < NUM_REGS;
  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

  always_comb begin
    rd_word = '0;
    wr_hit  = '0;
    rd_hit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(ar_idx) == i) rd_word = reg_out[i*DW +: DW];
      wr_hit[i] = commit && (int'(commit_idx) == i) && !RO_MASK[i];
      rd_hit[i] = ar_fire && (int'(ar_idx) == i);
    end
  end

  always_comb begin
    rd_state_n = rd_state;
    arready_n  = S_AXI_ARREADY;
    rvalid_n   = S_AXI_RVALID;
    rresp_n    = S_AXI_RRESP;
    rdata_n    = S_AXI_RDATA;
    case (rd_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ar_fire) begin
          arready_n  = 1'b0;
          rvalid_n   = 1'b1;
          rresp_n    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rdata_n    = ar_in_range ? rd_word : '0;
          rd_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
          rd_state_n = R_IDLE;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state      <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      reg_wr_pulse  <= '0;
      reg_rd_pulse  <= '0;
    end else begin
      rd_state      <= rd_state_n;
      S_AXI_ARREADY <= arready_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_RRESP   <= rresp_n;
      S_AXI_RDATA   <= rdata_n;
      reg_wr_pulse  <= wr_hit;
      reg_rd_pulse  <= rd_hit;
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb/tb_axi4lite_regbank.sv - scoreboard bench for axi4lite_regbank
module tb_axi4lite_regbank;
  import axi4lite_regbank_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR*DW-1:0] RV = (512'h5A << 64);

  logic ACLK = 1'b0;
  logic ARESET;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*DW-1:0] reg_out, reg_in, exp_img;
  logic [NR-1:0] reg_wr_pulse, reg_rd_pulse;

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  int wr_cnt[NR] = '{default: 0};
  int rd_cnt[NR] = '{default: 0};

  axi4lite_regbank #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(16'h0020), .RESET_VALUES(RV)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in),
    .reg_wr_pulse(reg_wr_pulse), .reg_rd_pulse(reg_rd_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int sum_cnt(input int c[NR]);
    int s = 0;
    for (int i = 0; i < NR; i++) s += c[i];
    return s;
  endfunction

  // Monitor: scores responses at handshake and counts pulse cycles.
  always @(negedge ACLK) begin
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      check("b_expected_count", 512'(b_q.size()), 512'd1);
      if (b_q.size() > 0) check("bresp", 512'(S_AXI_BRESP), 512'(b_q.pop_front()));
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      check("r_expected_count", 512'(r_q.size()), 512'd1);
      if (r_q.size() > 0) check("rresp_rdata", 512'({S_AXI_RRESP, S_AXI_RDATA}), 512'(r_q.pop_front()));
    end
    for (int i = 0; i < NR; i++) begin
      if (reg_wr_pulse[i]) wr_cnt[i]++;
      if (reg_rd_pulse[i]) rd_cnt[i]++;
    end
  end

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int b_delay, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    b_q.push_back(exp_resp);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_BREADY = (b_delay == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_delay);
      S_AXI_WVALID = !w_done;
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    check("aw_w_accepted", 512'({aw_done, w_done}), 512'(2'b11));
    @(negedge ACLK);
    check("bvalid_latency", 512'(S_AXI_BVALID), 512'd1);
    if (b_delay > 0) S_AXI_AWVALID = 1;
    for (int k = 0; k < b_delay; k++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      check("bvalid_hold", 512'(S_AXI_BVALID), 512'd1);
      check("bresp_hold", 512'(S_AXI_BRESP), 512'(exp_resp));
      check("awready_blocked", 512'(S_AXI_AWREADY), 512'd0);
    end
    if (b_delay > 0) begin
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 0; S_AXI_BREADY = 1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_delay);
    bit done = 0, hs;
    int cyc = 0;
    r_q.push_back({exp_resp, exp_data});
    S_AXI_ARADDR = addr; S_AXI_RREADY = (r_delay == 0); S_AXI_ARVALID = 1;
    while (!done && cyc < 40) begin
      @(negedge ACLK);
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      done = hs; cyc++;
    end
    S_AXI_ARVALID = 0;
    check("ar_accepted", 512'(done), 512'd1);
    @(negedge ACLK);
    check("rvalid_latency", 512'(S_AXI_RVALID), 512'd1);
    if (r_delay > 0) S_AXI_ARVALID = 1;
    for (int k = 0; k < r_delay; k++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      check("rvalid_hold", 512'(S_AXI_RVALID), 512'd1);
      check("rdata_hold", 512'(S_AXI_RDATA), 512'(exp_data));
      check("arready_blocked", 512'(S_AXI_ARREADY), 512'd0);
    end
    if (r_delay > 0) begin
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, w5, r5;
    ARESET = 1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    reg_in = '0;
    reg_in[5*DW +: DW] = 32'hDEADBEEF;
    exp_img = RV;
    exp_img[5*DW +: DW] = 32'hDEADBEEF;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_readies", 512'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 512'd0);
    check("rst_valids", 512'({S_AXI_BVALID, S_AXI_RVALID}), 512'd0);
    check("rst_resp_data", 512'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 512'd0);
    check("rst_pulses", 512'({reg_wr_pulse, reg_rd_pulse}), 512'd0);
    check("rst_reg_out", reg_out, exp_img);
    @(posedge ACLK); #1;
    ARESET = 0;
    @(negedge ACLK);
    check("awready_before_edge", 512'(S_AXI_AWREADY), 512'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("readies_after_edge", 512'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 512'(3'b111));
    @(posedge ACLK); #1;

    // Sequential writes then read-back.
    for (int i = 0; i < 4; i++) axi_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, RESP_OKAY);
    for (int i = 0; i < 4; i++) axi_read(8'(i*4), 32'(i+1), RESP_OKAY, 0);
    for (int i = 0; i < 4; i++) begin
      check("wr_pulse_once", 512'(wr_cnt[i]), 512'd1);
      check("rd_pulse_once", 512'(rd_cnt[i]), 512'd1);
    end
    axi_read(8'h0E, 32'h4, RESP_OKAY, 0);
    check("unaligned_rd_pulse", 512'(rd_cnt[3]), 512'd2);

    // W leads AW by three cycles, partial strobes.
    axi_write(8'h08, 32'h11223344, 4'hF, 0, 0, RESP_OKAY);
    axi_write(8'h08, 32'hAABBCCDD, 4'b0101, 3, 0, RESP_OKAY);
    axi_read(8'h08, 32'h11BB33DD, RESP_OKAY, 0);
    exp_img[0*DW +: DW] = 32'h1;
    exp_img[1*DW +: DW] = 32'h2;
    exp_img[2*DW +: DW] = 32'h11BB33DD;
    exp_img[3*DW +: DW] = 32'h4;
    check("reg_out_strb", reg_out, exp_img);

    // Out-of-range accesses.
    w0 = sum_cnt(wr_cnt); r0 = sum_cnt(rd_cnt);
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_SLVERR);
    axi_read(8'h7C, 32'h0, RESP_SLVERR, 0);
    check("oor_wr_pulses", 512'(sum_cnt(wr_cnt) - w0), 512'd0);
    check("oor_rd_pulses", 512'(sum_cnt(rd_cnt) - r0), 512'd0);
    check("oor_reg_out", reg_out, exp_img);

    // Read-only register.
    w5 = wr_cnt[5]; r5 = rd_cnt[5];
    axi_write(8'h14, 32'h12345678, 4'hF, 0, 0, RESP_OKAY);
    axi_read(8'h14, 32'hDEADBEEF, RESP_OKAY, 0);
    check("ro_no_wr_pulse", 512'(wr_cnt[5] - w5), 512'd0);
    check("ro_rd_pulse", 512'(rd_cnt[5] - r5), 512'd1);
    check("ro_reg_out", reg_out, exp_img);

    // Back-pressure on B and R.
    axi_write(8'h04, 32'h00000055, 4'hF, 0, 10, RESP_OKAY);
    axi_read(8'h04, 32'h00000055, RESP_OKAY, 10);
    exp_img[1*DW +: DW] = 32'h55;
    check("bp_reg_out", reg_out, exp_img);

    // Reset while a write response is pending.
    S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    @(negedge ACLK);
    check("pre_rst_bvalid", 512'(S_AXI_BVALID), 512'd1);
    check("pre_rst_reg2", 512'(reg_out[2*DW +: DW]), 512'h77);
    #1 ARESET = 1;
    #1;
    check("rst_bvalid_async", 512'(S_AXI_BVALID), 512'd0);
    check("rst_reg2_async", 512'(reg_out[2*DW +: DW]), 512'h5A);
    @(posedge ACLK); #1;
    ARESET = 0;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1;
    axi_read(8'h08, 32'h0000005A, RESP_OKAY, 0);

    repeat (2) @(posedge ACLK);
    check("b_q_drained", 512'(b_q.size()), 512'd0);
    check("r_q_drained", 512'(r_q.size()), 512'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
